uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one UART transmitter among NUM_REQ byte sources (round-robin, one byte per frame) and owns the baud divisor.
// Latency: req sampled high at edge N -> tx_start/ack pulse for the single cycle N..N+1; next grant only after the frame ends.
// Backpressure: sources hold req/req_data until ack; while active no grant is made and pending requests wait for IDLE.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req, req_data       per-source request and byte (source i at req_data[8i+7:8i])
//   ack                 one-hot one-cycle pulse: byte of source i taken
//   baud_cfg            requested divisor (0 ignored); tx_baud_control is the latched copy,
//                       only updated in IDLE so a frame never sees a divisor change
//   tx_start, tx_data   start strobe and byte to the transmitter; tx_busy is its frame-in-progress flag
//   grant_id, active    last granted index; high whenever the FSM is not IDLE
//   err                 sticky: transmitter did not go busy within BUSY_TIMEOUT cycles
//
// Build option: UART_ARB_FIXED_PRIO_EN pins the search pointer at 0 (fixed priority, lowest index wins).

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BAUD_W       = 16,
  parameter int RST_BAUD     = 8,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  input  logic [BAUD_W-1:0]    baud_cfg,
  output logic [BAUD_W-1:0]    tx_baud_control,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 active,
  output logic                 err
);

  localparam int               CNT_W     = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [2:0]       LAST_IDX  = 3'(NUM_REQ - 1);
  localparam logic [3:0]       NUM_REQ_W = 4'(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state, state_nxt;
  logic [2:0]         ptr, ptr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_REQ-1:0] ack_nxt;
  logic               tx_start_nxt;
  logic [7:0]         tx_data_nxt;
  logic [2:0]         grant_id_nxt;
  logic               err_nxt;
  logic [BAUD_W-1:0]  baud_nxt;

  // Round-robin search: rotate the request vector so ptr lands at bit 0,
  // take the lowest set bit, then rotate the offset back to an index.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 win_vld;
  logic [2:0]           win_off;
  logic [3:0]           win_sum;
  logic [2:0]           win_idx;

  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: NUM_REQ];

  always_comb begin
    win_vld = |req_rot;
    win_off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) win_off = 3'(i);
    end
    win_sum = {1'b0, ptr} + {1'b0, win_off};
    win_idx = (win_sum >= NUM_REQ_W) ? 3'(win_sum - NUM_REQ_W) : win_sum[2:0];
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    cnt_nxt      = cnt;
    ack_nxt      = '0;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    grant_id_nxt = grant_id;
    err_nxt      = err;
    baud_nxt     = tx_baud_control;
    unique case (state)
      IDLE: begin
        // Latch ahead of the grant decision, so a divisor change on the
        // grant edge already applies to the frame being started.
        if (baud_cfg != '0) baud_nxt = baud_cfg;
        if (win_vld) begin
          state_nxt    = WAIT_BUSY;
          cnt_nxt      = '0;
          tx_start_nxt = 1'b1;
          ack_nxt      = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          tx_data_nxt  = req_data[8*win_idx +: 8];
          grant_id_nxt = win_idx;
`ifdef UART_ARB_FIXED_PRIO_EN
          ptr_nxt      = '0;
`else
          ptr_nxt      = (win_idx == LAST_IDX) ? 3'd0 : win_idx + 3'd1;
`endif
        end
      end
      WAIT_BUSY: begin
        // The transmitter cannot have reacted during the strobe cycle,
        // so busy is only examined once tx_start has dropped.
        if (!tx_start) begin
          if (tx_busy) begin
            state_nxt = WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            err_nxt   = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      ptr             <= '0;
      cnt             <= '0;
      ack             <= '0;
      tx_start        <= 1'b0;
      tx_data         <= '0;
      grant_id        <= '0;
      err             <= 1'b0;
      tx_baud_control <= BAUD_W'(RST_BAUD);
    end else begin
      state           <= state_nxt;
      ptr             <= ptr_nxt;
      cnt             <= cnt_nxt;
      ack             <= ack_nxt;
      tx_start        <= tx_start_nxt;
      tx_data         <= tx_data_nxt;
      grant_id        <= grant_id_nxt;
      err             <= err_nxt;
      tx_baud_control <= baud_nxt;
    end
  end

  assign active = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester and transmitter models plus a grant scoreboard.
// Stimulus pushes expected grants; a negedge monitor pops one per tx_start.
// Directed checks cover reset values, baud latching, timeout and reset mid-frame.

module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;

  logic                 clk;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [15:0]          baud_cfg;
  logic [15:0]          tx_baud_control;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [2:0]           grant_id;
  logic                 active;
  logic                 err;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ), .BAUD_W(16), .RST_BAUD(8), .BUSY_TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .baud_cfg(baud_cfg), .tx_baud_control(tx_baud_control), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id), .active(active),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]         id;
    logic [7:0]         data;
    logic [NUM_REQ-1:0] ack;
  } exp_t;

  exp_t exp_q[$];

  // Per-requester byte sources
  logic [7:0] src_mem [NUM_REQ][8];
  int         src_wr  [NUM_REQ];
  int         src_rd  [NUM_REQ];

  int   busy_len   = 80;
  logic busy_stuck = 1'b0;
  logic prev_start = 1'b0;
  int   order [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_src(input int i, input logic [7:0] b);
    src_mem[i][src_wr[i]] = b;
    src_wr[i]++;
  endtask

  task automatic expect_grant(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = 3'(id);
    e.data = d;
    e.ack  = NUM_REQ'(1) << id;
    exp_q.push_back(e);
  endtask

  task automatic wait_start(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (tx_start === 1'b1) break;
    end
    check("wait_start", 32'(tx_start), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && active === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    check("wait_idle", 32'(done), 32'd1);
  endtask

  // Requester model: holds req with its current byte until acked.
  initial begin
    req      = '0;
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack[i] === 1'b1 && src_rd[i] < src_wr[i]) src_rd[i]++;
        if (src_rd[i] < src_wr[i]) begin
          req[i]             = 1'b1;
          req_data[8*i +: 8] = src_mem[i][src_rd[i][2:0]];
        end else begin
          req[i]             = 1'b0;
          req_data[8*i +: 8] = 8'h00;
        end
      end
    end
  end

  // Transmitter model: busy from the negedge after tx_start for busy_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && !busy_stuck) begin
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_start) begin
        check("start_one_cycle", 32'(tx_start), 32'd0);
        check("ack_one_cycle", 32'(ack), 32'd0);
      end
      if (tx_start === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got id=%0d data=0x%0h, required no grant", grant_id, tx_data);
        end else begin
          e = exp_q.pop_front();
          check("grant_id", 32'(grant_id), 32'(e.id));
          check("tx_data", 32'(tx_data), 32'(e.data));
          check("ack", 32'(ack), 32'(e.ack));
        end
      end
      prev_start = tx_start;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef UART_ARB_FIXED_PRIO_EN
    order = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
    order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    reset    = 1'b1;
    baud_cfg = 16'd0;

    // Reset values
    tick(3);
    check("rst_baud", 32'(tx_baud_control), 32'd8);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick(1);
    check("baud_zero_ignored", 32'(tx_baud_control), 32'd8);
    baud_cfg = 16'd16;
    tick(1);
    check("baud_latch_16", 32'(tx_baud_control), 32'd16);

    // Single request, 80-cycle frame
    busy_len = 80;
    expect_grant(0, 8'h55);
    push_src(0, 8'h55);
    wait_start(20);
    begin
      logic seen_low;
      seen_low = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk); #2;
        if (tx_busy === 1'b0 && k > 2) begin
          seen_low = 1'b1;
          break;
        end
      end
      check("busy_fell", 32'(seen_low), 32'd1);
    end
    check("active_before_edge", 32'(active), 32'd1);
    @(posedge clk); #1;
    check("active_after_edge", 32'(active), 32'd0);
    check("tx_data_held", 32'(tx_data), 32'h55);

    // Round-robin with all four requesting, two bytes each
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    busy_len = 4;
    for (int k = 0; k < 8; k++) expect_grant(order[k], 8'hA0 + 8'(order[k]));
    for (int i = 0; i < NUM_REQ; i++) begin
      push_src(i, 8'hA0 + 8'(i));
      push_src(i, 8'hA0 + 8'(i));
    end
    wait_idle(500);

    // Baud change mid-frame is deferred until IDLE
    busy_len = 20;
    expect_grant(2, 8'h3C);
    push_src(2, 8'h3C);
    wait_start(20);
    baud_cfg = 16'd32;
    tick(3);
    check("baud_frozen_mid_frame", 32'(tx_baud_control), 32'd16);
    wait_idle(100);
    check("baud_still_16_at_idle", 32'(tx_baud_control), 32'd16);
    tick(1);
    check("baud_latch_32", 32'(tx_baud_control), 32'd32);

    // Busy timeout
    busy_stuck = 1'b1;
    expect_grant(1, 8'h77);
    push_src(1, 8'h77);
    wait_start(20);
    tick(1);
    tick(14);
    check("err_before_timeout", 32'(err), 32'd0);
    check("active_before_timeout", 32'(active), 32'd1);
    tick(1);
    check("err_at_timeout", 32'(err), 32'd1);
    check("idle_after_timeout", 32'(active), 32'd0);
    busy_stuck = 1'b0;
    expect_grant(3, 8'h99);
    push_src(3, 8'h99);
    wait_idle(100);
    check("err_sticky", 32'(err), 32'd1);

    // Reset during WAIT_DONE with requests pending
    busy_len = 30;
    expect_grant(0, 8'h11);
    push_src(0, 8'h11);
    push_src(0, 8'h12);
    wait_start(20);
    tick(4);
    push_src(2, 8'h22);
    reset = 1'b1;
    tick(1);
    check("rst_mid_active", 32'(active), 32'd0);
    check("rst_mid_tx_start", 32'(tx_start), 32'd0);
    check("rst_mid_ack", 32'(ack), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    check("rst_mid_baud", 32'(tx_baud_control), 32'd8);
    begin
      logic low;
      low = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (tx_busy === 1'b0) begin
          low = 1'b1;
          break;
        end
        tick(1);
      end
      check("busy_idle_in_reset", 32'(low), 32'd1);
    end
    expect_grant(0, 8'h12);
    expect_grant(2, 8'h22);
    reset = 1'b0;
    wait_idle(300);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
